alu_req_ctrl: RTL and testbench

//  Initiator side of the ALU operand/control interface. Accepts ALU op requests on a

---
 rtl/alu_req_ctrl_if.sv | 54 +++++
 rtl/alu_req_ctrl.sv | 131 +++++++++++++
 tb/tb_alu_req_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/alu_req_ctrl_if.sv
// Request / ALU-drive / response bundle between a sequencer and alu_req_ctrl.
// rsp_flags exists only when ALU_FLAGS_EN is defined.
interface alu_req_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;
`ifdef ALU_FLAGS_EN
  logic [2:0]       rsp_flags;
`endif

  // master: sequencer plus the ALU itself; slave: the controller
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag,
    input  req_ready,
    input  alu_a, alu_b, alu_control,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
`ifdef ALU_FLAGS_EN
    input  rsp_flags,
`endif
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag,
    output req_ready,
    output alu_a, alu_b, alu_control,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_result, rsp_zero, rsp_tag, rsp_err,
`ifdef ALU_FLAGS_EN
    output rsp_flags,
`endif
    input  rsp_ready
  );
endinterface

// File: rtl/alu_req_ctrl.sv
// ALU request controller: one execute stage driving an external ALU, then a response FIFO.
// Define ALU_FLAGS_EN to add the {N,C,V} rsp_flags output.
module alu_req_ctrl #(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  alu_req_ctrl_if.slave    bus,
  output logic             busy
);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             err;
`ifdef ALU_FLAGS_EN
    logic [2:0]       flags;
`endif
  } ent_t;

  logic             e_valid_q, e_valid_d;
  logic [2:0]       e_op_q;
  logic [WIDTH-1:0] e_a_q, e_b_q;
  logic [TAG_W-1:0] e_tag_q;

  ent_t             mem_q [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic req_ready, req_fire, e_adv, pop;
  ent_t push_ent, head;

  always_comb begin
    pop       = (cnt_q != '0) && bus.rsp_ready;
    e_adv     = e_valid_q && ((cnt_q < CNT_W'(RSP_DEPTH)) || pop);
    req_ready = !e_valid_q || e_adv;
    req_fire  = bus.req_valid && req_ready;
    e_valid_d = e_valid_q;
    if (req_fire)   e_valid_d = 1'b1;
    else if (e_adv) e_valid_d = 1'b0;
  end

  // Operand registers only load on accept, so the ALU inputs hold while idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_valid_q <= 1'b0;
      e_op_q    <= '0;
      e_a_q     <= '0;
      e_b_q     <= '0;
      e_tag_q   <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      if (req_fire) begin
        e_op_q  <= bus.req_op;
        e_a_q   <= bus.req_a;
        e_b_q   <= bus.req_b;
        e_tag_q <= bus.req_tag;
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.alu_a       = e_a_q;
  assign bus.alu_b       = e_b_q;
  assign bus.alu_control = e_op_q;

`ifdef ALU_FLAGS_EN
  logic             is_add, is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  always_comb begin
    is_add = (e_op_q == 3'b000);
    is_sub = (e_op_q == 3'b001);
    b_eff  = is_sub ? ~e_b_q : e_b_q;
    sum    = {1'b0, e_a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  end
`endif

  always_comb begin
    push_ent        = '0;
    push_ent.result = bus.alu_result;
    push_ent.zero   = bus.alu_zero;
    push_ent.tag    = e_tag_q;
    push_ent.err    = (e_op_q == 3'b100) || (e_op_q == 3'b110) || (e_op_q == 3'b111);
`ifdef ALU_FLAGS_EN
    // Overflow: operand signs agree but the sum's sign differs.
    push_ent.flags  = {bus.alu_result[WIDTH-1],
                       (is_add || is_sub) && sum[WIDTH],
                       (is_add || is_sub) && (e_a_q[WIDTH-1] == b_eff[WIDTH-1])
                                          && (sum[WIDTH-1] != e_a_q[WIDTH-1])};
`endif
  end

  // When full, a same-cycle push overwrites the slot being popped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (e_adv) begin
        mem_q[wr_ptr_q] <= push_ent;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({e_adv, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign bus.rsp_valid  = (cnt_q != '0);
  assign bus.rsp_result = head.result;
  assign bus.rsp_zero   = head.zero;
  assign bus.rsp_tag    = head.tag;
  assign bus.rsp_err    = head.err;
`ifdef ALU_FLAGS_EN
  assign bus.rsp_flags  = head.flags;
`endif

  assign busy = e_valid_q || (cnt_q != '0);
endmodule

// File: tb/tb_alu_req_ctrl.sv
// Directed bench for alu_req_ctrl with a behavioural ALU hooked to the alu_* signals.
module tb_alu_req_ctrl;
  localparam int W  = 32;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_req_ctrl_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  alu_req_ctrl #(.WIDTH(W), .TAG_W(TW), .RSP_DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  // Reference ALU: add, sub, and, or, slt; anything else returns 0.
  always_comb begin
    case (bus.alu_control)
      3'b000:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b101:  bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      default: bus.alu_result = '0;
    endcase
  end
  assign bus.alu_zero = (bus.alu_result == '0);

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the request until accepted, bounded to 50 cycles.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] tag);
    int n;
    bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_tag = tag;
    bus.req_valid = 1'b1;
    n = 0;
    #1;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 50) chk("send_timeout", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Single op on an idle pipe with rsp_ready=1; response expected one edge after accept.
  task automatic do_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [TW-1:0] tag,
                       input logic [W-1:0] exp_res, input logic exp_z, input logic exp_err);
    send(op, a, b, tag);
    tick();
    chk({name, "_valid"}, bus.rsp_valid, 1);
    chk({name, "_result"}, bus.rsp_result, exp_res);
    chk({name, "_zero"}, bus.rsp_zero, exp_z);
    chk({name, "_tag"}, bus.rsp_tag, tag);
    chk({name, "_err"}, bus.rsp_err, exp_err);
    tick();
  endtask

  initial begin
    int got;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.req_tag = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();

    // 1: latency and fields for add 5+7
    send(3'b000, 32'd5, 32'd7, 4'd3);
    chk("t1_alu_a", bus.alu_a, 5);
    chk("t1_alu_b", bus.alu_b, 7);
    chk("t1_lat_not_yet", bus.rsp_valid, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_result", bus.rsp_result, 12);
    chk("t1_zero", bus.rsp_zero, 0);
    chk("t1_tag", bus.rsp_tag, 3);
    chk("t1_err", bus.rsp_err, 0);
    tick();
    chk("t1_drained", bus.rsp_valid, 0);
    chk("t1_idle", busy, 0);
    chk("t1_alu_hold", bus.alu_a, 5);

    // 2: zero flag and slt
    do_op("t2_sub", 3'b001, 32'd9, 32'd9, 4'd1, 32'd0, 1'b1, 1'b0);
    do_op("t2_slt", 3'b101, 32'd2, 32'd7, 4'd2, 32'd1, 1'b0, 1'b0);
    do_op("t2_and", 3'b010, 32'hF0F0, 32'h3C3C, 4'd4, 32'h3030, 1'b0, 1'b0);

    // 3: backpressure fills E + FIFO, then drains in order while streaming resumes
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(3'b000, W'(3 * k), 32'd1, TW'(k));
    chk("t3_full_ready", bus.req_ready, 0);
    chk("t3_busy", busy, 1);
    repeat (3) tick();
    chk("t3_still_blocked", bus.req_ready, 0);
    chk("t3_head_tag", bus.rsp_tag, 0);
    chk("t3_head_stable", bus.rsp_result, 1);
    bus.rsp_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int k = 3; k < 6; k++) send(3'b000, W'(3 * k), 32'd1, TW'(k));
      end
      begin
        for (int c = 0; c < 40 && got < 6; c++) begin
          if (bus.rsp_valid) begin
            chk("t3_order_tag", bus.rsp_tag, got);
            chk("t3_order_res", bus.rsp_result, 3 * got + 1);
            got++;
          end
          tick();
        end
      end
    join
    chk("t3_count", got, 6);
    tick();
    chk("t3_idle", busy, 0);

    // 4: illegal op then a legal one
    do_op("t4_ill", 3'b111, 32'd1, 32'd1, 4'd5, 32'd0, 1'b1, 1'b1);
    do_op("t4_next", 3'b011, 32'h10, 32'h01, 4'd6, 32'h11, 1'b0, 1'b0);

    // 5: async reset with a full FIFO
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(3'b000, 32'd100, W'(k), TW'(7 + k));
    chk("t5_pre_valid", bus.rsp_valid, 1);
    reset = 1'b0;
    #1;
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_req_ready", bus.req_ready, 1);
    chk("t5_alu_a", bus.alu_a, 0);
    tick();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    tick();
    do_op("t5_after", 3'b000, 32'd20, 32'd22, 4'd9, 32'd42, 1'b0, 1'b0);

`ifdef ALU_FLAGS_EN
    // 6: NCV flags
    send(3'b000, 32'h7FFFFFFF, 32'd1, 4'd1);
    tick();
    chk("t6_add_res", bus.rsp_result, 32'h80000000);
    chk("t6_add_flags", bus.rsp_flags, 3'b101);
    tick();
    send(3'b001, 32'd0, 32'd1, 4'd2);
    tick();
    chk("t6_sub_res", bus.rsp_result, 32'hFFFFFFFF);
    chk("t6_sub_flags", bus.rsp_flags, 3'b100);
    tick();
    send(3'b001, 32'd5, 32'd3, 4'd3);
    tick();
    chk("t6_sub_carry", bus.rsp_flags, 3'b010);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
